// File: rtl/rv_axi_rd_arb.sv
// AXI read-channel arbiter: merges NCH client AR channels onto one AXI master
// and routes R beats back to the issuing client by rid or by issue order.
//
// state | meaning
// IDLE  | no AR offered; pick a winner if a slot is free
// ADDR  | AR of channel gnt_q offered on the AXI master port
module rv_axi_rd_arb #(
    parameter int NCH       = 2,
    parameter int ADDR_W    = 28,
    parameter int ID_W      = 3,
    parameter int ARB_MODE  = 0,
    parameter int RID_ROUTE = 0,
    parameter int MAX_OUTST = 4
) (
    input  logic                        aclk,
    input  logic                        arst_n,
    input  logic [NCH*ADDR_W-1:0]       c_araddr,
    input  logic [NCH*8-1:0]            c_arlen,
    input  logic [NCH-1:0]              c_arvalid,
    output logic [NCH-1:0]              c_arready,
    output logic [NCH-1:0]              c_rvalid,
    output logic [NCH-1:0]              c_rlast,
    input  logic [NCH-1:0]              c_rready,
    output logic [31:0]                 c_rdata,
    output logic [1:0]                  c_rresp,
    output logic [ADDR_W-1:0]           araddr,
    output logic [7:0]                  arlen,
    output logic [ID_W-1:0]             arid,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [ID_W-1:0]             rid,
    input  logic [31:0]                 rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic                        rvalid,
    output logic                        rready,
    output logic [$clog2(MAX_OUTST):0]  outst,
    output logic                        err
);

    localparam int SEL_W = $clog2(NCH);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        ADDR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]   rr_ptr_q;
    logic [SEL_W-1:0]   win;
    logic               found;
    int                 idx;

    logic [SEL_W-1:0]   fifo_q [MAX_OUTST];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   outst_q;
    logic               err_q;

    logic               push, pop, full;
    logic               rid_oob, route_ok;
    logic [SEL_W-1:0]   sel;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (outst_q == CNT_W'(MAX_OUTST));

    // Winner search; round-robin scans starting just after the last grant.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < NCH; i++) begin
                if (!found && c_arvalid[i]) begin
                    win   = SEL_W'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                idx = (int'(rr_ptr_q) + k) % NCH;
                if (!found && c_arvalid[idx]) begin
                    win   = SEL_W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        arvalid   = 1'b0;
        araddr    = '0;
        arlen     = '0;
        arid      = '0;
        c_arready = '0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (found && !full) begin
                    state_d = ADDR;
                    gnt_d   = win;
                end
            end
            ADDR: begin
                arvalid          = 1'b1;
                araddr           = c_araddr[int'(gnt_q)*ADDR_W +: ADDR_W];
                arlen            = c_arlen[int'(gnt_q)*8 +: 8];
                arid             = ID_W'(gnt_q);
                c_arready[gnt_q] = arready;
                if (arready) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= SEL_W'(NCH - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            if (push) begin
                rr_ptr_q <= gnt_q;
            end
        end
    end

    // Unroutable beats (nothing outstanding, or rid naming no client) are
    // swallowed so the interconnect never stalls on them.
    assign rid_oob  = ({1'b0, rid} >= (ID_W+1)'(NCH));
    assign route_ok = (outst_q != '0) && !((RID_ROUTE != 0) && rid_oob);
    assign sel      = (RID_ROUTE != 0) ? rid[SEL_W-1:0] : fifo_q[rd_ptr_q];

    always_comb begin
        c_rvalid = '0;
        c_rlast  = '0;
        rready   = 1'b1;
        if (route_ok) begin
            rready        = c_rready[sel];
            c_rvalid[sel] = rvalid;
            c_rlast[sel]  = rlast;
        end
    end

    assign c_rdata = rdata;
    assign c_rresp = rresp;
    assign pop     = rvalid && rready && rlast && route_ok;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= gnt_q;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                outst_q <= outst_q + 1'b1;
            end else if (pop && !push) begin
                outst_q <= outst_q - 1'b1;
            end
            if ((rvalid && !route_ok) || (rvalid && rready && (rresp != 2'b00))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign outst = outst_q;
    assign err   = err_q;

endmodule

// File: tb/tb_rv_axi_rd_arb.sv
// Directed bench: dut0 = 2 clients, fixed priority, in-order routing, 2 slots;
// dut1 = 4 clients, round-robin, rid routing, 8 slots.
module tb_rv_axi_rd_arb;

    int checks = 0;
    int errors = 0;
    int beats1 = 0;

    logic aclk = 1'b0;
    logic arst_n;
    always #5 aclk = ~aclk;

    // dut0 signals
    logic [55:0] c_araddr0;
    logic [15:0] c_arlen0;
    logic [1:0]  c_arvalid0, c_arready0, c_rvalid0, c_rlast0, c_rready0;
    logic [31:0] c_rdata0, rdata0;
    logic [1:0]  c_rresp0, rresp0;
    logic [27:0] araddr0;
    logic [7:0]  arlen0;
    logic [2:0]  arid0, rid0;
    logic        arvalid0, arready0, rlast0, rvalid0, rready0, err0;
    logic [1:0]  outst0;

    // dut1 signals
    logic [111:0] c_araddr1;
    logic [31:0]  c_arlen1;
    logic [3:0]   c_arvalid1, c_arready1, c_rvalid1, c_rlast1, c_rready1;
    logic [31:0]  c_rdata1, rdata1;
    logic [1:0]   c_rresp1, rresp1;
    logic [27:0]  araddr1;
    logic [7:0]   arlen1;
    logic [2:0]   arid1, rid1;
    logic         arvalid1, arready1, rlast1, rvalid1, rready1, err1;
    logic [3:0]   outst1;

    rv_axi_rd_arb #(.NCH(2), .ADDR_W(28), .ID_W(3), .ARB_MODE(0), .RID_ROUTE(0), .MAX_OUTST(2)) dut0 (
        .aclk(aclk), .arst_n(arst_n),
        .c_araddr(c_araddr0), .c_arlen(c_arlen0), .c_arvalid(c_arvalid0), .c_arready(c_arready0),
        .c_rvalid(c_rvalid0), .c_rlast(c_rlast0), .c_rready(c_rready0),
        .c_rdata(c_rdata0), .c_rresp(c_rresp0),
        .araddr(araddr0), .arlen(arlen0), .arid(arid0), .arvalid(arvalid0), .arready(arready0),
        .rid(rid0), .rdata(rdata0), .rresp(rresp0), .rlast(rlast0), .rvalid(rvalid0), .rready(rready0),
        .outst(outst0), .err(err0)
    );

    rv_axi_rd_arb #(.NCH(4), .ADDR_W(28), .ID_W(3), .ARB_MODE(1), .RID_ROUTE(1), .MAX_OUTST(8)) dut1 (
        .aclk(aclk), .arst_n(arst_n),
        .c_araddr(c_araddr1), .c_arlen(c_arlen1), .c_arvalid(c_arvalid1), .c_arready(c_arready1),
        .c_rvalid(c_rvalid1), .c_rlast(c_rlast1), .c_rready(c_rready1),
        .c_rdata(c_rdata1), .c_rresp(c_rresp1),
        .araddr(araddr1), .arlen(arlen1), .arid(arid1), .arvalid(arvalid1), .arready(arready1),
        .rid(rid1), .rdata(rdata1), .rresp(rresp1), .rlast(rlast1), .rvalid(rvalid1), .rready(rready1),
        .outst(outst1), .err(err1)
    );

    always @(posedge aclk) begin
        if (rvalid0 && rready0 && c_rvalid0[1]) beats1 <= beats1 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        arst_n = 1'b0;
        c_araddr0 = '0; c_arlen0 = '0; c_arvalid0 = '0; c_rready0 = '0; arready0 = 1'b0;
        rid0 = '0; rdata0 = '0; rresp0 = '0; rlast0 = 1'b0; rvalid0 = 1'b0;
        c_araddr1 = '0; c_arlen1 = '0; c_arvalid1 = '0; c_rready1 = '0; arready1 = 1'b0;
        rid1 = '0; rdata1 = '0; rresp1 = '0; rlast1 = 1'b0; rvalid1 = 1'b0;
        #1;
        chk("rst_arvalid0", 64'(arvalid0), 64'd0);
        chk("rst_araddr0", 64'(araddr0), 64'd0);
        chk("rst_outst0", 64'(outst0), 64'd0);
        chk("rst_err0", 64'(err0), 64'd0);
        chk("rst_c_rvalid0", 64'(c_rvalid0), 64'd0);
        chk("rst_arvalid1", 64'(arvalid1), 64'd0);
        @(negedge aclk); @(negedge aclk);
        arst_n = 1'b1;

        // fixed priority: both request together
        @(negedge aclk);
        c_araddr0 = {28'h0000200, 28'h0000100}; c_arlen0 = {8'd3, 8'd0};
        c_arvalid0 = 2'b11; arready0 = 1'b1;
        #1 chk("fp_idle_arvalid", 64'(arvalid0), 64'd0);
        @(negedge aclk); #1;
        chk("fp_g0_arvalid", 64'(arvalid0), 64'd1);
        chk("fp_g0_arid", 64'(arid0), 64'd0);
        chk("fp_g0_araddr", 64'(araddr0), 64'h100);
        chk("fp_g0_arlen", 64'(arlen0), 64'd0);
        chk("fp_g0_c_arready", 64'(c_arready0), 64'b01);
        @(negedge aclk);
        c_arvalid0 = 2'b10;
        #1;
        chk("fp_gap_arvalid", 64'(arvalid0), 64'd0);
        chk("fp_gap_araddr", 64'(araddr0), 64'd0);
        chk("fp_gap_outst", 64'(outst0), 64'd1);
        @(negedge aclk); #1;
        chk("fp_g1_arvalid", 64'(arvalid0), 64'd1);
        chk("fp_g1_arid", 64'(arid0), 64'd1);
        chk("fp_g1_araddr", 64'(araddr0), 64'h200);
        chk("fp_g1_arlen", 64'(arlen0), 64'd3);
        chk("fp_g1_c_arready", 64'(c_arready0), 64'b10);

        // third request with both slots used must stall
        @(negedge aclk);
        c_arvalid0 = 2'b01;
        #1 chk("full_outst", 64'(outst0), 64'd2);
        @(negedge aclk); #1;
        chk("full_arvalid", 64'(arvalid0), 64'd0);
        chk("full_c_arready", 64'(c_arready0), 64'd0);
        chk("full_outst2", 64'(outst0), 64'd2);

        // in-order return: ch0 single beat, then ch1 four beats
        c_arvalid0 = 2'b00; arready0 = 1'b0;
        rvalid0 = 1'b1; rlast0 = 1'b1; rdata0 = 32'hA0; c_rready0 = 2'b11;
        #1;
        chk("io_ch0_c_rvalid", 64'(c_rvalid0), 64'b01);
        chk("io_ch0_c_rlast", 64'(c_rlast0), 64'b01);
        chk("io_ch0_rready", 64'(rready0), 64'd1);
        chk("io_ch0_c_rdata", 64'(c_rdata0), 64'hA0);
        @(negedge aclk);
        rlast0 = 1'b0; rdata0 = 32'hB0;
        #1;
        chk("io_pop_outst", 64'(outst0), 64'd1);
        chk("io_ch1_c_rvalid", 64'(c_rvalid0), 64'b10);
        chk("io_ch1_c_rlast", 64'(c_rlast0), 64'b00);
        @(negedge aclk);
        rdata0 = 32'hB1; c_rready0 = 2'b01;
        #1;
        chk("bp_rready_a", 64'(rready0), 64'd0);
        chk("bp_c_rvalid", 64'(c_rvalid0), 64'b10);
        @(negedge aclk); #1 chk("bp_rready_b", 64'(rready0), 64'd0);
        @(negedge aclk); #1 chk("bp_rready_c", 64'(rready0), 64'd0);
        chk("bp_outst", 64'(outst0), 64'd1);
        @(negedge aclk);
        c_rready0 = 2'b11;
        #1;
        chk("bp_release_rready", 64'(rready0), 64'd1);
        chk("bp_release_rdata", 64'(c_rdata0), 64'hB1);
        @(negedge aclk);
        rdata0 = 32'hB2;
        @(negedge aclk);
        rdata0 = 32'hB3; rlast0 = 1'b1;
        #1 chk("io_ch1_last", 64'(c_rlast0), 64'b10);
        @(negedge aclk);
        rvalid0 = 1'b0; rlast0 = 1'b0;
        #1;
        chk("io_done_outst", 64'(outst0), 64'd0);
        chk("io_done_err", 64'(err0), 64'd0);
        chk("io_ch1_beats", 64'(beats1), 64'd4);

        // stray beat with nothing outstanding
        @(negedge aclk);
        rvalid0 = 1'b1; rlast0 = 1'b1; rdata0 = 32'hC0; c_rready0 = 2'b00;
        #1;
        chk("stray_rready", 64'(rready0), 64'd1);
        chk("stray_c_rvalid", 64'(c_rvalid0), 64'd0);
        @(negedge aclk);
        rvalid0 = 1'b0; rlast0 = 1'b0;
        #1;
        chk("stray_err", 64'(err0), 64'd1);
        chk("stray_outst", 64'(outst0), 64'd0);

        // round-robin: all four request continuously
        @(negedge aclk);
        c_araddr1 = {28'h0001030, 28'h0001020, 28'h0001010, 28'h0001000};
        c_arlen1 = {8'd3, 8'd2, 8'd1, 8'd0};
        c_arvalid1 = 4'b1111; arready1 = 1'b1;
        #1 chk("rr_idle_arvalid", 64'(arvalid1), 64'd0);
        for (int g = 0; g < 5; g++) begin
            @(negedge aclk); #1;
            chk("rr_arvalid", 64'(arvalid1), 64'd1);
            chk("rr_arid", 64'(arid1), 64'(rr_exp[g]));
            chk("rr_araddr", 64'(araddr1), 64'(28'h1000 + 16 * rr_exp[g]));
            chk("rr_c_arready", 64'(c_arready1), 64'(4'b0001 << rr_exp[g]));
            @(negedge aclk); #1;
            chk("rr_gap_arvalid", 64'(arvalid1), 64'd0);
        end
        c_arvalid1 = 4'b0000;
        chk("rr_outst", 64'(outst1), 64'd5);

        // rid routing: ch2 returns first
        @(negedge aclk);
        rvalid1 = 1'b1; rid1 = 3'd2; rlast1 = 1'b1; rdata1 = 32'hD2; rresp1 = 2'd0; c_rready1 = 4'b1111;
        #1;
        chk("rid_ch2_c_rvalid", 64'(c_rvalid1), 64'b0100);
        chk("rid_ch2_c_rlast", 64'(c_rlast1), 64'b0100);
        chk("rid_ch2_rready", 64'(rready1), 64'd1);
        chk("rid_ch2_c_rdata", 64'(c_rdata1), 64'hD2);
        @(negedge aclk);
        rid1 = 3'd0; rresp1 = 2'd2; rdata1 = 32'hE0;
        #1;
        chk("rid_pop_outst", 64'(outst1), 64'd4);
        chk("rid_ch0_c_rvalid", 64'(c_rvalid1), 64'b0001);
        chk("rid_ch0_c_rresp", 64'(c_rresp1), 64'd2);
        chk("rid_pre_err", 64'(err1), 64'd0);
        @(negedge aclk);
        rid1 = 3'd5; rresp1 = 2'd0; c_rready1 = 4'b0000;
        #1;
        chk("slverr_outst", 64'(outst1), 64'd3);
        chk("slverr_err", 64'(err1), 64'd1);
        chk("oob_rready", 64'(rready1), 64'd1);
        chk("oob_c_rvalid", 64'(c_rvalid1), 64'd0);
        @(negedge aclk);
        rid1 = 3'd1; rlast1 = 1'b0; c_arvalid1 = 4'b0001;
        #1;
        chk("oob_outst", 64'(outst1), 64'd3);
        chk("rid_ch1_c_rvalid", 64'(c_rvalid1), 64'b0010);

        // reset mid-burst with AR pending and R valid
        @(negedge aclk); #1;
        chk("pre_rst_arvalid", 64'(arvalid1), 64'd1);
        chk("pre_rst_arid", 64'(arid1), 64'd0);
        #2 arst_n = 1'b0;
        #1;
        chk("mid_rst_arvalid", 64'(arvalid1), 64'd0);
        chk("mid_rst_araddr", 64'(araddr1), 64'd0);
        chk("mid_rst_arid", 64'(arid1), 64'd0);
        chk("mid_rst_c_arready", 64'(c_arready1), 64'd0);
        chk("mid_rst_c_rvalid", 64'(c_rvalid1), 64'd0);
        chk("mid_rst_c_rlast", 64'(c_rlast1), 64'd0);
        chk("mid_rst_outst1", 64'(outst1), 64'd0);
        chk("mid_rst_err1", 64'(err1), 64'd0);
        chk("mid_rst_err0", 64'(err0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
